// File: rtl/voting_pkg.sv
// Shared constants and FSM state type for the voting machine front end.
package voting_pkg;

  localparam int unsigned NUM_CAND = 4;
  localparam int unsigned VOTE_W   = 8;
  localparam logic [VOTE_W-1:0] VOTE_MAX = 8'hFF;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_RELEASE
  } vote_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a saturating-stability debounce counter for one button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned DB_CNT_W        = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic stable_o
);

  logic [1:0]          sync_q;
  logic                stable_q, stable_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    // Count only while the synced level disagrees with the accepted level.
    if (sync_q[1] != stable_q) begin
      if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], button_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/vote_logger.sv
// Debounced one-vote-per-press logger with saturating per-candidate tallies.
module vote_logger
  import voting_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned DB_CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic [4:1]        button_raw,
  output logic              valid_vote_casted,
  output logic [VOTE_W-1:0] cand_1_vote,
  output logic [VOTE_W-1:0] cand_2_vote,
  output logic [VOTE_W-1:0] cand_3_vote,
  output logic [VOTE_W-1:0] cand_4_vote,
  output logic [4:1]        candidate_button_press,
  output logic              vote_overflow
);

  logic [NUM_CAND-1:0] stable;
  logic [VOTE_W-1:0]   tally_q [NUM_CAND];
  logic [VOTE_W-1:0]   tally_d [NUM_CAND];
  vote_state_e         state_q, state_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_CNT_W       (DB_CNT_W)
    ) u_db (
      .clk_i   (clock),
      .rst_ni  (reset),
      .button_i(button_raw[g+1]),
      .stable_o(stable[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    tally_d    = tally_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (|stable) begin
          state_d = WAIT_RELEASE;
          // Only a lone press in voting mode is a vote; anything else just arms release.
          if (!mode && $onehot(stable)) begin
            for (int unsigned k = 0; k < NUM_CAND; k++) begin
              if (stable[k]) begin
                if (tally_q[k] != VOTE_MAX) begin
                  tally_d[k] = tally_q[k] + 1'b1;
                  valid_d    = 1'b1;
                end else begin
                  overflow_d = 1'b1;
                end
              end
            end
          end
        end
      end
      WAIT_RELEASE: begin
        if (!(|stable)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tally_q    <= '{default: '0};
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tally_q    <= tally_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_vote_casted      = valid_q;
  assign vote_overflow          = overflow_q;
  assign candidate_button_press = stable;
  assign cand_1_vote            = tally_q[0];
  assign cand_2_vote            = tally_q[1];
  assign cand_3_vote            = tally_q[2];
  assign cand_4_vote            = tally_q[3];

endmodule

// File: tb/tb_vote_logger.sv
// Directed self-checking bench for vote_logger with DEBOUNCE_CYCLES = 4.
module tb_vote_logger;

  logic       clock;
  logic       reset;
  logic       mode;
  logic [4:1] button_raw;
  logic       valid_vote_casted;
  logic [7:0] cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote;
  logic [4:1] candidate_button_press;
  logic       vote_overflow;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  vote_logger #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W       (16)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .mode                  (mode),
    .button_raw            (button_raw),
    .valid_vote_casted     (valid_vote_casted),
    .cand_1_vote           (cand_1_vote),
    .cand_2_vote           (cand_2_vote),
    .cand_3_vote           (cand_3_vote),
    .cand_4_vote           (cand_4_vote),
    .candidate_button_press(candidate_button_press),
    .vote_overflow         (vote_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, settle, and tally any vote pulse seen.
  task automatic tick();
    @(posedge clock);
    #1;
    if (valid_vote_casted === 1'b1) pulses++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_tallies(input string name, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3, input logic [7:0] e4);
    checks++;
    if ({cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote} !== {e1, e2, e3, e4}) begin
      errors++;
      $display("FAIL %s: tallies got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", name,
               cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote, e1, e2, e3, e4);
    end
  endtask

  task automatic check_pulses(input string name, input int expected);
    checks++;
    if (pulses !== expected) begin
      errors++;
      $display("FAIL %s: vote pulses got %0d want %0d", name, pulses, expected);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      button_raw = 4'(i + 5);
      tick();
      checks++;
      if ({valid_vote_casted, vote_overflow, candidate_button_press, cand_1_vote, cand_2_vote,
           cand_3_vote, cand_4_vote} !== 38'd0) begin
        errors++;
        $display("FAIL reset_hold: outputs got v=%b o=%b p=%b t=%0d/%0d/%0d/%0d want all 0",
                 valid_vote_casted, vote_overflow, candidate_button_press, cand_1_vote,
                 cand_2_vote, cand_3_vote, cand_4_vote);
      end
    end
    button_raw = 4'b0000;
    tick();
    reset = 1'b1;
    hold(10);
  endtask

  task automatic test_single_vote();
    pulses = 0;
    button_raw = 4'b0010;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++;
      if (cand_2_vote !== ((n >= 7) ? 8'd1 : 8'd0) ||
          valid_vote_casted !== ((n == 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL first_vote_timing edge %0d: cand_2=%0d valid=%b want %0d/%b", n,
                 cand_2_vote, valid_vote_casted, (n >= 7) ? 1 : 0, (n == 7) ? 1 : 0);
      end
    end
    check_pulses("first_vote_pulse", 1);
    button_raw = 4'b0000;
    hold(10);
    pulses = 0;
    button_raw = 4'b0010;
    hold(12);
    check_pulses("second_vote_pulse", 1);
    check_tallies("second_vote", 8'd0, 8'd2, 8'd0, 8'd0);
    button_raw = 4'b0000;
    hold(10);
  endtask

  task automatic test_glitch();
    pulses = 0;
    button_raw = 4'b0001;
    hold(3);
    button_raw = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (candidate_button_press !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_level: press got %b want 0000", candidate_button_press);
      end
    end
    check_pulses("glitch_pulse", 0);
    check_tallies("glitch_tally", 8'd0, 8'd2, 8'd0, 8'd0);
  endtask

  task automatic test_multi_press();
    pulses = 0;
    button_raw = 4'b0101;
    hold(15);
    checks++;
    if (candidate_button_press !== 4'b0101) begin
      errors++;
      $display("FAIL multi_level: press got %b want 0101", candidate_button_press);
    end
    check_pulses("multi_pulse", 0);
    check_tallies("multi_tally", 8'd0, 8'd2, 8'd0, 8'd0);
    button_raw = 4'b0000;
    hold(10);
    pulses = 0;
    button_raw = 4'b0100;
    hold(10);
    check_pulses("cand3_pulse", 1);
    check_tallies("cand3_tally", 8'd0, 8'd2, 8'd1, 8'd0);
    button_raw = 4'b0000;
    hold(10);
  endtask

  task automatic test_mode_switch();
    pulses = 0;
    mode = 1'b1;
    button_raw = 4'b1000;
    hold(10);
    checks++;
    if (candidate_button_press !== 4'b1000) begin
      errors++;
      $display("FAIL result_mode_level: press got %b want 1000", candidate_button_press);
    end
    mode = 1'b0;
    hold(10);
    check_pulses("mode_switch_pulse", 0);
    check_tallies("mode_switch_tally", 8'd0, 8'd2, 8'd1, 8'd0);
    button_raw = 4'b0000;
    hold(10);
    pulses = 0;
    button_raw = 4'b1000;
    hold(10);
    check_pulses("cand4_pulse", 1);
    check_tallies("cand4_tally", 8'd0, 8'd2, 8'd1, 8'd1);
    button_raw = 4'b0000;
    hold(10);
  endtask

  task automatic test_saturation();
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      button_raw = 4'b0001;
      hold(8);
      button_raw = 4'b0000;
      hold(8);
    end
    check_pulses("fill_pulses", 255);
    check_tallies("fill_tally", 8'd255, 8'd2, 8'd1, 8'd1);
    checks++;
    if (vote_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_early: got %b want 0", vote_overflow);
    end
    pulses = 0;
    button_raw = 4'b0001;
    hold(10);
    check_pulses("sat_pulse", 0);
    check_tallies("sat_tally", 8'd255, 8'd2, 8'd1, 8'd1);
    button_raw = 4'b0000;
    hold(10);
    checks++;
    if (vote_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b want 1", vote_overflow);
    end
  endtask

  task automatic test_reset_while_held();
    button_raw = 4'b0001;
    hold(10);
    reset = 1'b0;
    #1;
    checks++;
    if ({valid_vote_casted, vote_overflow, candidate_button_press, cand_1_vote, cand_2_vote,
         cand_3_vote, cand_4_vote} !== 38'd0) begin
      errors++;
      $display("FAIL async_reset: outputs got o=%b p=%b t=%0d/%0d/%0d/%0d want all 0",
               vote_overflow, candidate_button_press, cand_1_vote, cand_2_vote, cand_3_vote,
               cand_4_vote);
    end
    hold(3);
    reset = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (cand_1_vote !== ((n >= 7) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL held_after_reset edge %0d: cand_1 got %0d want %0d", n, cand_1_vote,
                 (n >= 7) ? 1 : 0);
      end
    end
    check_pulses("held_after_reset_pulse", 1);
    checks++;
    if (vote_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_after_reset: got %b want 0", vote_overflow);
    end
  endtask

  initial begin
    reset = 1'b0;
    mode = 1'b0;
    button_raw = 4'b0000;
    test_reset();
    test_single_vote();
    test_glitch();
    test_multi_press();
    test_mode_switch();
    test_saturation();
    test_reset_while_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
